// File: rtl/ram_bytelane.sv
`default_nettype none
// ============================================================================
// ram_bytelane : data RAM with byte-lane stores and sign/zero-extended loads
// Revision     : 1.0
// ============================================================================
module ram_bytelane #(
    parameter int WORDS     = 2048,
    parameter int AW        = $clog2(WORDS),
    parameter int ZERO_IDLE = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        misaligned
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [31:0]   mem [WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          bad;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic          unused_addr;

    logic [31:0]   data_out_d,   data_out_q;
    logic          data_valid_d, data_valid_q;
    logic          misaligned_d, misaligned_q;

    assign word_idx    = data_address[AW+1:2];
    assign offset      = data_address[1:0];
    assign unused_addr = ^data_address[31:AW+2];

    always_comb begin
        bad = 1'b0;
        be  = 4'b0000;
        wdata = data_in;
        case (mem_size)
            c_SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{data_in[7:0]}};
            end
            c_SZ_HALF: begin
                bad   = offset[0];
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_in[15:0]}};
            end
            c_SZ_WORD: begin
                bad = (offset != 2'b00);
                be  = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
    end

    // Writes are held off during reset so a stray store cannot corrupt the array.
    assign wr_en = rst_n && mem_write && !bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first: the array is sampled before this edge's write lands.
    assign rd_word = mem[word_idx];

    always_comb begin
        byte_sel = rd_word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (mem_size)
            c_SZ_BYTE: load_val = {{24{~mem_unsigned & byte_sel[7]}}, byte_sel};
            c_SZ_HALF: load_val = {{16{~mem_unsigned & half_sel[15]}}, half_sel};
            default:   load_val = rd_word;
        endcase
    end

    always_comb begin
        data_valid_d = mem_read && !bad;
        misaligned_d = (mem_read || mem_write) && bad;
        if (data_valid_d) begin
            data_out_d = load_val;
        end else if (ZERO_IDLE != 0) begin
            data_out_d = 32'h0;
        end else begin
            data_out_d = data_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q   <= 32'h0;
            data_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign misaligned = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bytelane.sv
`default_nettype none
// ============================================================================
// tb_ram_bytelane : vector table, scoreboard and byte-level reference model
// Revision        : 1.0
// ============================================================================
module tb_ram_bytelane;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_address = 32'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b10;
    logic        mem_unsigned = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out, data_out_h;
    logic        data_valid, data_valid_h;
    logic        misaligned, misaligned_h;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_bytelane #(.WORDS(2048), .ZERO_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_address(data_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .misaligned(misaligned)
    );

    ram_bytelane #(.WORDS(2048), .ZERO_IDLE(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .data_address(data_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .data_in(data_in),
        .data_out(data_out_h), .data_valid(data_valid_h), .misaligned(misaligned_h)
    );

    typedef struct {
        logic [31:0] dout;
        logic        valid;
        logic        mis;
        string       name;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] eout;
        logic        ev;
        logic        em;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[$];
    logic [7:0]  mdl [0:8191];
    logic [31:0] hold_exp = 32'h0;

    function automatic logic mdl_good(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd0) || (sz == 2'd1 && !a[0]) || (sz == 2'd2 && a[1:0] == 2'd0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
        logic [12:0] b;
        logic [7:0]  v8;
        logic [15:0] v16;
        b   = a[12:0];
        v8  = mdl[b];
        v16 = {mdl[b + 13'd1], mdl[b]};
        if (sz == 2'd0) return uns ? {24'h0, v8} : {{24{v8[7]}}, v8};
        if (sz == 2'd1) return uns ? {16'h0, v16} : {{16{v16[15]}}, v16};
        return {mdl[b + 13'd3], mdl[b + 13'd2], v16};
    endfunction

    task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [12:0] b;
        b = a[12:0];
        mdl[b] = d[7:0];
        if (sz != 2'd0) mdl[b + 13'd1] = d[15:8];
        if (sz == 2'd2) begin
            mdl[b + 13'd2] = d[23:16];
            mdl[b + 13'd3] = d[31:24];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request per call: expectation queued at drive time, popped after the edge.
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] din,
                         input logic [31:0] eout, input logic ev, input logic em,
                         input string name);
        exp_t e;
        mem_read = rd;  mem_write = wr;  mem_size = sz;
        mem_unsigned = uns;  data_address = addr;  data_in = din;
        e.dout = eout;  e.valid = ev;  e.mis = em;  e.name = name;
        sb_q.push_back(e);
        if (rst_n && wr && mdl_good(sz, addr)) mdl_store(sz, addr, din);
        @(posedge clk);
        #1;
        if (!rst_n)  hold_exp = 32'h0;
        else if (ev) hold_exp = eout;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_data_out"},   data_out,            e.dout);
            chk({e.name, "_valid"},      {31'd0, data_valid}, {31'd0, e.valid});
            chk({e.name, "_misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
            chk({e.name, "_hold_out"},   data_out_h,          hold_exp);
            chk({e.name, "_hold_valid"}, {31'd0, data_valid_h}, {31'd0, e.valid});
            chk({e.name, "_hold_mis"},   {31'd0, misaligned_h}, {31'd0, e.mis});
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] din,
                       input logic [31:0] eout, input logic ev, input logic em);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.din = din;
        v.eout = eout; v.ev = ev; v.em = em;
        tbl.push_back(v);
    endtask

    initial begin
        logic        rd, wr, uns, good;
        logic [1:0]  sz;
        logic [31:0] a, d, eo;

        // Word path, byte lanes, halfwords, misalignment, collision, wrap, idle, back-to-back
        add(0,1,2,0,32'h10,32'hDEADBEEF,32'h0,0,0);
        add(1,0,2,0,32'h10,32'h0,32'hDEADBEEF,1,0);
        add(0,1,0,0,32'h12,32'h5A,32'h0,0,0);
        add(1,0,2,0,32'h10,32'h0,32'hDE5ABEEF,1,0);
        add(1,0,0,0,32'h13,32'h0,32'hFFFFFFDE,1,0);
        add(1,0,0,1,32'h13,32'h0,32'h000000DE,1,0);
        add(1,0,0,0,32'h12,32'h0,32'h0000005A,1,0);
        add(1,0,0,0,32'h10,32'h0,32'hFFFFFFEF,1,0);
        add(0,1,2,0,32'h20,32'h0,32'h0,0,0);
        add(0,1,1,0,32'h22,32'h8001,32'h0,0,0);
        add(1,0,2,0,32'h20,32'h0,32'h80010000,1,0);
        add(1,0,1,0,32'h22,32'h0,32'hFFFF8001,1,0);
        add(1,0,1,1,32'h22,32'h0,32'h00008001,1,0);
        add(1,0,1,0,32'h20,32'h0,32'h00000000,1,0);
        add(0,1,2,0,32'h40,32'h01020304,32'h0,0,0);
        add(0,1,2,0,32'h41,32'h11111111,32'h0,0,1);
        add(1,0,2,0,32'h40,32'h0,32'h01020304,1,0);
        add(1,0,1,0,32'h43,32'h0,32'h0,0,1);
        add(1,0,3,0,32'h40,32'h0,32'h0,0,1);
        add(0,1,2,0,32'h50,32'hAAAAAAAA,32'h0,0,0);
        add(1,1,2,0,32'h50,32'h12345678,32'hAAAAAAAA,1,0);
        add(1,0,2,0,32'h50,32'h0,32'h12345678,1,0);
        add(0,1,2,0,32'h2004,32'hCAFEF00D,32'h0,0,0);
        add(1,0,2,0,32'h4,32'h0,32'hCAFEF00D,1,0);
        add(0,0,2,0,32'h0,32'h0,32'h0,0,0);
        add(0,1,2,0,32'h0,32'h11223344,32'h0,0,0);
        add(0,1,2,0,32'h8,32'h55667788,32'h0,0,0);
        add(1,0,2,0,32'h0,32'h0,32'h11223344,1,0);
        add(1,0,2,0,32'h4,32'h0,32'hCAFEF00D,1,0);
        add(1,0,2,0,32'h8,32'h0,32'h55667788,1,0);
        add(0,0,2,0,32'h0,32'h0,32'h0,0,0);

        // Reset held two cycles with a read pending: nothing valid
        rst_n = 1'b0;
        drive(1,0,2,0,32'h10,32'h0,32'h0,0,0,"rst0");
        drive(1,0,2,0,32'h10,32'h0,32'h0,0,0,"rst1");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].din,
                  tbl[i].eout, tbl[i].ev, tbl[i].em, $sformatf("vec%0d", i));
        end

        // Randomised traffic over a preloaded window, checked against the byte model
        for (int i = 0; i < 16; i++) begin
            drive(0,1,2,0,32'h100 + 32'(4*i),$urandom,32'h0,0,0,$sformatf("fill%0d", i));
        end
        for (int i = 0; i < 80; i++) begin
            rd  = 1'($urandom_range(0,1));
            wr  = 1'($urandom_range(0,1));
            sz  = 2'($urandom_range(0,3));
            uns = 1'($urandom_range(0,1));
            a   = 32'h100 + 32'($urandom_range(0,63));
            d   = $urandom;
            good = mdl_good(sz, a);
            eo  = (rd && good) ? mdl_load(sz, uns, a) : 32'h0;
            drive(rd, wr, sz, uns, a, d, eo, rd && good, (rd || wr) && !good,
                  $sformatf("rnd%0d", i));
        end

        // Store during reset is suppressed; a load just before reset is discarded
        drive(0,1,2,0,32'h60,32'h0BADF00D,32'h0,0,0,"pre_rst_sw");
        rst_n = 1'b0;
        drive(1,1,2,0,32'h60,32'hFFFFFFFF,32'h0,0,0,"rst_sw");
        rst_n = 1'b1;
        drive(1,0,2,0,32'h60,32'h0,32'h0BADF00D,1,0,"post_rst_lw");
        drive(1,0,2,0,32'h60,32'h0,32'h0BADF00D,1,0,"mid_lw");
        rst_n = 1'b0;
        drive(0,0,2,0,32'h0,32'h0,32'h0,0,0,"mid_rst");
        rst_n = 1'b1;
        drive(0,0,2,0,32'h0,32'h0,32'h0,0,0,"post_mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
